q2_memio: RTL and testbench
===========================

Name: q2_memio

Overview:
- Memory and I/O responder for the q2 CPU bus, sitting directly downstream of the CPU top.
- Consumes abus, wrm and rdm, and returns read data on the shared bidirectional dbus.
- Contains a RAM of 12-bit words plus two memory-mapped teletype registers at the top of the address space.
- The teletype transmit register feeds an 8N1 serial transmitter used as the machine's console output.

Parameters:
RAM_WORDS, 4096, number of 12-bit RAM words; addresses at or above RAM_WORDS read 0 and ignore writes, except the I/O addresses.
CLKS_PER_BIT, 434, clk cycles per serial bit (legal range 2..4095).
TTY_STAT_ADDR, 12'hFFE, address of the status register.
TTY_DATA_ADDR, 12'hFFF, address of the transmit data register.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, synchronous, active-high.
abus  input  12  address from the CPU.
dbus  inout  12  data bus; driven only during qualified reads, otherwise high-Z.
wrm  input  1  memory write strobe from the CPU (level).
rdm  input  1  memory read strobe from the CPU (level).
tx  output  1  serial output, idle high.
tx_busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Effects: tx=1, tx_busy=0, state=IDLE, overrun=0, bit counter=0, baud timer=0, wrm_q=0.
  - RAM contents are preserved, not cleared.
  - A reset during a frame aborts it; tx is 1 after that edge.
- Write detect:
  - wrm is registered into wrm_q.
  - A write event occurs on the clk edge where wrm=1 and wrm_q=0.
  - There is exactly one write per wrm pulse, using abus/dbus as sampled at that edge.
- RAM write: on a write event with abus < RAM_WORDS and abus not an I/O address, RAM[abus] <= dbus.
- Read:
  - The dbus drive is combinational.
  - dbus = rd_data whenever rdm=1 and wrm=0; otherwise high-Z.
  - If rdm and wrm are both high, wrm wins and dbus is not driven.
- rd_data:
  - abus==TTY_STAT_ADDR: {10'b0, overrun, tx_busy}.
  - abus==TTY_DATA_ADDR: {4'b0, last written byte}.
  - abus < RAM_WORDS: RAM[abus].
  - Otherwise: 0.
- Write to TTY_DATA_ADDR:
  - If state==IDLE: latch dbus[7:0] into the shift register and go to START on the same edge.
  - If not IDLE: data is dropped and overrun <= 1.
- Write to TTY_STAT_ADDR: overrun <= 0 regardless of data; other bits are read-only.
- Transmitter FSM (IDLE -> START -> DATA -> STOP -> IDLE):
  - Each bit is held for exactly CLKS_PER_BIT cycles by a down-counting baud timer, reloaded with CLKS_PER_BIT-1 on every bit boundary.
  - START: tx=0.
  - DATA: 8 bits, LSB first; the bit counter runs 0..7.
  - STOP: tx=1.
  - tx and tx_busy are registered.
  - tx falls and tx_busy rises on the edge of the write event.
  - tx_busy falls exactly 10*CLKS_PER_BIT cycles later, at the end of STOP.
- Back-to-back frames: a write arriving on the same edge that STOP completes is treated as busy and sets overrun. Software must poll tx_busy=0 first.
- Both simultaneous-write cases above are covered by the same rule: the write to TTY_DATA_ADDR is the only path that starts a frame.

Test Plan:
- Reset and RAM write/read:
  - Stimulus: rst 2 cycles; then write 12'hA5C to addr 12'h010 (wrm pulse 3 cycles); then rdm=1 at 12'h010.
  - Required: dbus=12'hA5C; the write occurs exactly once; dbus is Z when rdm=0.
- Address edge cases:
  - With RAM_WORDS=256: write to 12'h100, then read it -> dbus=0.
  - Read 12'h0FF after writing 12'h123 -> 12'h123.
  - rdm and wrm both high -> dbus Z.
- Serial frame:
  - Stimulus: CLKS_PER_BIT=4, write 12'hF41 to 12'hFFF.
  - Required: tx sequence per 4-cycle bit is 0,1,0,0,0,0,0,1,0,1.
  - Required: tx_busy high for 40 cycles; reading 12'hFFF returns 12'h041.
- Overrun:
  - Stimulus: write 12'h055 to 12'hFFF mid-frame.
  - Required: frame unchanged; status reads 12'h003 during the frame and 12'h002 after.
  - Then write 12'h000 to 12'hFFE -> status 12'h000.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3.
  - Required: next edge gives tx=1, tx_busy=0, status 0; RAM word written before reset still reads back unchanged.
- Completion-edge write:
  - Stimulus: write to 12'hFFF on the exact edge STOP ends.
  - Required: overrun=1 and no new frame; a write one cycle later starts a frame normally.

Source files
------------

// File: rtl/q2_memio.sv
// q2 bus memory/I-O responder: 12-bit RAM, teletype status/data registers,
// and an 8N1 console transmitter driven from the data register.
module q2_memio #(
  parameter int unsigned RAM_WORDS     = 4096,
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter logic [11:0] TTY_STAT_ADDR = 12'hFFE,
  parameter logic [11:0] TTY_DATA_ADDR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  logic [11:0] dbus,
  input  logic        wrm,
  input  logic        rdm,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned AW          = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [11:0] BAUD_RELOAD = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [11:0] mem [RAM_WORDS];
  logic        wrm_q;
  logic        wr_ev;
  logic        is_stat;
  logic        is_data;
  logic        in_ram;
  logic [11:0] rd_data;
  logic [7:0]  last_byte;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [11:0] baud;
  logic        overrun;
  tx_state_t   state;

  assign wr_ev   = wrm & ~wrm_q;
  assign is_stat = (abus == TTY_STAT_ADDR);
  assign is_data = (abus == TTY_DATA_ADDR);
  // I/O addresses shadow any RAM word that would sit at the same location
  assign in_ram  = ({20'd0, abus} < RAM_WORDS) && !is_stat && !is_data;

  always_ff @(posedge clk) begin
    if (!rst && wr_ev && in_ram)
      mem[abus[AW-1:0]] <= dbus;
  end

  always_comb begin
    rd_data = '0;
    if (is_stat)
      rd_data = {10'b0, overrun, tx_busy};
    else if (is_data)
      rd_data = {4'b0, last_byte};
    else if (in_ram)
      rd_data = mem[abus[AW-1:0]];
  end

  // A simultaneous write strobe keeps the bus free for the CPU's write data
  assign dbus = (rdm && !wrm) ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      overrun <= 1'b0;
      bit_cnt <= '0;
      baud    <= '0;
      wrm_q   <= 1'b0;
    end else begin
      wrm_q <= wrm;
      if (wr_ev && is_data)
        last_byte <= dbus[7:0];
      if (wr_ev && is_stat)
        overrun <= 1'b0;

      if (state == IDLE) begin
        if (wr_ev && is_data) begin
          shreg   <= dbus[7:0];
          state   <= START;
          tx      <= 1'b0;
          tx_busy <= 1'b1;
          baud    <= BAUD_RELOAD;
        end
      end else begin
        // Any data write while a frame is in flight, including the edge
        // on which STOP finishes, is dropped and flagged.
        if (wr_ev && is_data)
          overrun <= 1'b1;
        if (baud != '0) begin
          baud <= baud - 12'd1;
        end else begin
          baud <= BAUD_RELOAD;
          unique case (state)
            START: begin
              state   <= DATA;
              tx      <= shreg[0];
              bit_cnt <= '0;
            end
            DATA: begin
              if (bit_cnt == 3'd7) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                tx      <= shreg[1];
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            STOP: begin
              state   <= IDLE;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_q2_memio.sv
// Directed plus randomized bench for q2_memio: RAM, I/O registers and serial frames.
module tb_q2_memio;

  localparam int unsigned RAM_W = 256;
  localparam int          CPB   = 4;
  localparam logic [11:0] STAT  = 12'hFFE;
  localparam logic [11:0] DATA  = 12'hFFF;
  localparam logic [11:0] REL   = 12'hFFF; // value of the pulled-up bus when nobody drives

  logic        clk;
  logic        rst;
  logic [11:0] abus;
  logic        wrm;
  logic        rdm;
  logic        tx;
  logic        tx_busy;
  logic [11:0] tb_dout;
  logic        tb_drive;
  tri1  [11:0] dbus;

  assign dbus = tb_drive ? tb_dout : 'z;

  q2_memio #(
    .RAM_WORDS(RAM_W),
    .CLKS_PER_BIT(CPB),
    .TTY_STAT_ADDR(STAT),
    .TTY_DATA_ADDR(DATA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .abus(abus),
    .dbus(dbus),
    .wrm(wrm),
    .rdm(rdm),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [11:0] ref_mem [int unsigned];
  logic [11:0] waddr_q [$];
  logic        ovr_exp;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [11:0] mem_exp(input logic [11:0] a);
    if (32'(a) < RAM_W) return ref_mem[32'(a)];
    return '0;
  endfunction

  task automatic rd(input logic [11:0] a, output logic [11:0] d);
    abus = a;
    rdm  = 1'b1;
    #1;
    d    = dbus;
    rdm  = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [11:0] exp);
    logic [11:0] v;
    @(negedge clk);
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // One wrm pulse of len cycles; data changes after the first edge so a
  // repeated write would be visible.
  task automatic wr(input logic [11:0] a, input logic [11:0] d, input int len);
    @(negedge clk);
    abus = a; tb_dout = d; tb_drive = 1'b1; wrm = 1'b1;
    @(negedge clk);
    for (int i = 1; i < len; i++) begin
      tb_dout = ~d;
      @(negedge clk);
    end
    wrm = 1'b0; tb_drive = 1'b0;
    @(negedge clk);
    if (a == STAT) ovr_exp = 1'b0;
    else if (32'(a) < RAM_W) ref_mem[32'(a)] = d;
    waddr_q.push_back(a);
  endtask

  // Starts a frame with byte d[7:0] and checks every cycle of it; optionally
  // injects a data write at cycle ovr_at and a reset at cycle rst_at.
  task automatic frame(input logic [11:0] d, input int ovr_at, input int rst_at);
    logic [9:0]  f;
    logic [11:0] st;
    bit          aborted;
    f = {1'b1, d[7:0], 1'b0};
    aborted = 1'b0;
    @(negedge clk);
    abus = DATA; tb_dout = d; tb_drive = 1'b1; wrm = 1'b1;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      wrm = 1'b0; tb_drive = 1'b0;
      chk("frame_tx", 12'(tx), 12'(f[k / CPB]));
      chk("frame_busy", 12'(tx_busy), 12'd1);
      if (k == 2 || (ovr_at >= 0 && k == ovr_at + 3)) begin
        rd(STAT, st);
        chk("status_in_frame", st, {10'b0, ovr_exp, 1'b1});
      end
      if (k == ovr_at) begin
        abus = DATA; tb_dout = 12'h055; tb_drive = 1'b1; wrm = 1'b1;
        ovr_exp = 1'b1;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", 12'(tx), 12'd1);
        chk("rst_busy", 12'(tx_busy), 12'd0);
        ovr_exp = 1'b0;
        rd(STAT, st);
        chk("rst_status", st, 12'h000);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      wrm = 1'b0; tb_drive = 1'b0;
      chk("frame_end_busy", 12'(tx_busy), 12'd0);
      chk("frame_end_tx", 12'(tx), 12'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    logic [11:0] d;
    logic [11:0] v;
    rst = 1'b1; abus = '0; wrm = 1'b0; rdm = 1'b0;
    tb_dout = '0; tb_drive = 1'b0; ovr_exp = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_tx", 12'(tx), 12'd1);
    chk("reset_busy", 12'(tx_busy), 12'd0);
    rd(STAT, v);
    chk("reset_status", v, 12'h000);
    #1;
    chk("reset_bus_released", dbus, REL);
    rst = 1'b0;

    wr(12'h010, 12'hA5C, 3);
    rdchk("ram_010", 12'h010, 12'hA5C);
    #1;
    chk("bus_released_rdm0", dbus, REL);

    wr(12'h0FF, 12'h123, 1);
    wr(12'h000, 12'h777, 2);
    wr(12'h100, 12'h5A5, 1);
    wr(12'h020, 12'h9B6, 1);
    rdchk("ram_0ff", 12'h0FF, 12'h123);
    rdchk("ram_000", 12'h000, 12'h777);
    rdchk("above_ram_100", 12'h100, 12'h000);
    rdchk("above_ram_ffd", 12'hFFD, 12'h000);

    @(negedge clk);
    abus = 12'h200; rdm = 1'b1; wrm = 1'b1; tb_drive = 1'b0;
    #1;
    chk("rd_wr_both_high", dbus, REL);
    @(negedge clk);
    rdm = 1'b0; wrm = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      a = 12'($urandom_range(0, 511));
      d = 12'($urandom);
      wr(a, d, int'($urandom_range(1, 3)));
    end
    foreach (waddr_q[i]) rdchk("rand_read", waddr_q[i], mem_exp(waddr_q[i]));
    for (int i = 0; i < 6; i++) begin
      a = 12'($urandom_range(256, 4093));
      rdchk("rand_above_ram", a, 12'h000);
    end

    frame(12'hF41, -1, -1);
    rdchk("data_reg", DATA, 12'h041);
    rdchk("status_idle", STAT, 12'h000);

    frame(12'h0C3, 15, -1);
    rdchk("status_after_overrun", STAT, 12'h002);
    wr(STAT, 12'h000, 1);
    rdchk("status_cleared", STAT, 12'h000);

    frame(12'h035, 5, 17);
    rdchk("ram_after_reset", 12'h020, 12'h9B6);
    rdchk("ram_010_after_reset", 12'h010, mem_exp(12'h010));

    frame(12'h0A6, 39, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_new_frame_busy", 12'(tx_busy), 12'd0);
      chk("no_new_frame_tx", 12'(tx), 12'd1);
    end
    rdchk("status_completion_write", STAT, 12'h002);
    frame(12'h05A, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
